// File: rtl/multiword_add_seq_if.sv
// Valid/ready operand and result bundle for multiword_add_seq.
// ADD_SUB_EN adds the sub select, captured alongside the operands.
interface multiword_add_seq_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned WORDS = 4
);
    localparam int unsigned W = WIDTH * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in0;
    logic [W-1:0] in1;
    logic         carry_in;
`ifdef ADD_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;
    logic         busy;

    modport slave (
`ifdef ADD_SUB_EN
        input  sub,
`endif
        input  in_valid, in0, in1, carry_in, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow, busy
    );

    modport master (
`ifdef ADD_SUB_EN
        output sub,
`endif
        output in_valid, in0, in1, carry_in, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow, busy
    );
endinterface

// File: rtl/multiword_add_seq.sv
// Multi-word adder: one WIDTH-bit adder stepped over WORDS cycles with a carry register.
// Define ADD_SUB_EN to enable subtraction via bus_io.sub.
module multiword_add_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    multiword_add_seq_if.slave   bus_io
);
    localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                       state_q, state_d;
    logic [IdxW-1:0]              idx_q, idx_d;
    logic                         carry_q, carry_d;
    logic [WORDS-1:0][WIDTH-1:0]  a_q, a_d;
    logic [WORDS-1:0][WIDTH-1:0]  b_q, b_d;
    logic [WORDS-1:0][WIDTH-1:0]  sum_q, sum_d;
    logic                         cout_q, cout_d;
    logic                         ovf_q, ovf_d;

    logic                         sub_w;
    logic [WIDTH:0]               word_sum;

`ifdef ADD_SUB_EN
    assign sub_w = bus_io.sub;
`else
    assign sub_w = 1'b0;
`endif

    assign word_sum = {1'b0, a_q[idx_q]} + {1'b0, b_q[idx_q]} + {{WIDTH{1'b0}}, carry_q};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.in_valid) begin
                    // Subtract stores ~B and ~cin so RUN only ever adds.
                    a_d     = bus_io.in0;
                    b_d     = sub_w ? ~bus_io.in1 : bus_io.in1;
                    carry_d = bus_io.carry_in ^ sub_w;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[idx_q] = word_sum[WIDTH-1:0];
                carry_d      = word_sum[WIDTH];
                if (idx_q == LastIdx) begin
                    cout_d  = word_sum[WIDTH];
                    ovf_d   = (a_q[WORDS-1][WIDTH-1] == b_q[WORDS-1][WIDTH-1]) &&
                              (word_sum[WIDTH-1] != a_q[WORDS-1][WIDTH-1]);
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (bus_io.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus_io.in_ready  = (state_q == StIdle);
    assign bus_io.out_valid = (state_q == StDone);
    assign bus_io.busy      = (state_q != StIdle);
    assign bus_io.sum       = sum_q;
    assign bus_io.carry_out = cout_q;
    assign bus_io.overflow  = ovf_q;
endmodule

// File: tb/tb_multiword_add_seq.sv
// Randomized bench for multiword_add_seq against a wide-arithmetic reference model.
// Define ADD_SUB_EN to also exercise subtraction.
module tb_multiword_add_seq;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = WIDTH * WORDS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    multiword_add_seq_if #(.WIDTH(WIDTH), .WORDS(WORDS)) bus ();

    multiword_add_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    // Returns {overflow, carry_out, sum} of the whole-width operation.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic cin, input logic sb);
        logic [W-1:0] be;
        logic         ce;
        logic [W:0]   full;
        logic         ovf;
        be   = sb ? ~b : b;
        ce   = sb ? ~cin : cin;
        full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ce};
        ovf  = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
        return {ovf, full[W], full[W-1:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic sub_in;
`ifdef ADD_SUB_EN
    assign bus.sub = sub_in;
`endif

    function automatic logic eff_sub();
`ifdef ADD_SUB_EN
        return bus.sub;
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: accept, then result WORDS edges later, held until handshake.
    logic         m_busy, m_valid;
    int           m_left;
    logic [W+1:0] m_pend, m_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_left  <= 0;
            m_pend  <= '0;
            m_res   <= '0;
        end else if (!m_busy) begin
            if (bus.in_valid) begin
                m_pend <= ref_op(bus.in0, bus.in1, bus.carry_in, eff_sub());
                m_left <= WORDS;
                m_busy <= 1'b1;
            end
        end else if (!m_valid) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_valid <= 1'b1;
                m_res   <= m_pend;
            end
        end else if (bus.out_ready) begin
            m_valid <= 1'b0;
            m_busy  <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("out_valid", 64'(bus.out_valid), 64'(m_valid));
            check("in_ready", 64'(bus.in_ready), 64'(!m_busy));
            check("busy", 64'(bus.busy), 64'(m_busy));
            if (m_valid) begin
                check("sum", 64'(bus.sum), 64'(m_res[W-1:0]));
                check("carry_out", 64'(bus.carry_out), 64'(m_res[W]));
                check("overflow", 64'(bus.overflow), 64'(m_res[W+1]));
            end
        end
    end

    // One full operation; noise drives ignored in_valid/operands while busy.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sb, input int hold, input bit noise,
                          output logic [W+1:0] got, output int lat);
        int waitc = 0;
        while (!bus.in_ready && waitc < 50) begin
            @(posedge clk);
            #1;
            waitc++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in0      = a;
        bus.in1      = b;
        bus.carry_in = cin;
        sub_in       = sb;
        @(posedge clk);
        #1;
        bus.in_valid = noise ? 1'($urandom) : 1'b0;
        bus.in0      = $urandom;
        bus.in1      = $urandom;
        bus.carry_in = 1'($urandom);
        sub_in       = 1'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (noise) begin
                bus.in_valid = 1'($urandom);
                bus.in0      = $urandom;
            end
        end
        if (!bus.out_valid) check("out_valid_timeout", 64'(bus.out_valid), 64'd1);
        got = {bus.overflow, bus.carry_out, bus.sum};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (noise) bus.in_valid = 1'($urandom);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
    endtask

    logic [W+1:0] got;
    int           lat;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in0       = '0;
        bus.in1       = '0;
        bus.carry_in  = 1'b0;
        bus.out_ready = 1'b0;
        sub_in        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sum", 64'(bus.sum), 64'd0);
        check("rst_cout", 64'(bus.carry_out), 64'd0);
        check("rst_ovf", 64'(bus.overflow), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("post_rst_busy", 64'(bus.busy), 64'd0);

        // Model pinned against hand-computed values.
        check("model_add", 64'(ref_op(32'h0000_00FF, 32'h0, 1'b1, 1'b0)),
              64'({1'b0, 1'b0, 32'h0000_0100}));
        check("model_ovf", 64'(ref_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0)),
              64'({1'b1, 1'b0, 32'h8000_0000}));
        check("model_sub", 64'(ref_op(32'h5, 32'h7, 1'b0, 1'b1)),
              64'({1'b0, 1'b0, 32'hFFFF_FFFE}));

        run_op(32'h0000_00FF, 32'h0, 1'b1, 1'b0, 0, 1'b0, got, lat);
        check("t1_sum", 64'(got), 64'({1'b0, 1'b0, 32'h0000_0100}));
        check("t1_latency", 64'(lat), 64'(WORDS));

        run_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1, 1'b0, got, lat);
        check("t2_sum", 64'(got), 64'({1'b0, 1'b1, 32'h0}));

        run_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 0, 1'b0, got, lat);
        check("t3_sum", 64'(got), 64'({1'b1, 1'b0, 32'h8000_0000}));

        run_op(32'hA5A5_0001, 32'h0F0F_FFFF, 1'b1, 1'b0, 10, 1'b1, got, lat);
        check("t4_sum", 64'(got), 64'({1'b0, 1'b0, 32'hB4B5_0001}));
        check("t4_in_ready_after", 64'(bus.in_ready), 64'd1);
        run_op(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 0, 1'b0, got, lat);
        check("t4_next_sum", 64'(got), 64'({1'b0, 1'b0, 32'h0000_0030}));

        // Reset two cycles into RUN drops the operation.
        bus.in_valid = 1'b1;
        bus.in0      = 32'hFFFF_0000;
        bus.in1      = 32'h0001_0000;
        bus.carry_in = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t5_out_valid", 64'(bus.out_valid), 64'd0);
        check("t5_sum", 64'(bus.sum), 64'd0);
        check("t5_cout", 64'(bus.carry_out), 64'd0);
        check("t5_ovf", 64'(bus.overflow), 64'd0);
        check("t5_busy", 64'(bus.busy), 64'd0);
        check("t5_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (WORDS + 2) @(posedge clk);
        #1;
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 0, 1'b0, got, lat);
        check("t5_next_sum", 64'(got), 64'({1'b0, 1'b0, 32'h2345_6789}));

`ifdef ADD_SUB_EN
        run_op(32'h5, 32'h7, 1'b0, 1'b1, 0, 1'b0, got, lat);
        check("t6_sub", 64'(got), 64'({1'b0, 1'b0, 32'hFFFF_FFFE}));
`endif

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a, b;
            logic         c, s;
            a = $urandom;
            b = $urandom;
            if (i % 4 == 0) a[W-1] = b[W-1];
            c = 1'($urandom);
`ifdef ADD_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            run_op(a, b, c, s, int'($urandom_range(0, 3)), 1'($urandom), got, lat);
            check("rand_result", 64'(got), 64'(ref_op(a, b, c, s)));
            check("rand_latency", 64'(lat), 64'(WORDS));
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
